fixed_to_float_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-register fixed-to-float converter.
- Converts an IN_WIDTH-bit fixed-point number into an IEEE-754-style float with EXP_W/MAN_W fields, at a binary point selectable per transaction.
- Adds signed/unsigned mode, truncate or round-nearest-even, inexact/overflow flags, and valid/ready flow control.
- Sits between fixed-point datapath producers and float consumers, sustaining one conversion per cycle.

---
 rtl/fixed_to_float_pipe.sv | 164 ++++++++++++++++
 tb/tb_fixed_to_float_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float_pipe.sv
// Pipelined fixed-point to IEEE-754-style float converter.
// Three registered stages (capture, normalise, round/pack) under one global
// advance signal, so any output stall freezes the whole pipe in place.
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready      input handshake
//   targetnumber           fixed-point operand, value = targetnumber * 2^-fixpointpos
//   fixpointpos            fractional bit count
//   in_signed, in_round    two's complement select, round-nearest-even select
//   out_valid/out_ready    output handshake
//   result                 {sign, exponent, mantissa}
//   out_inexact            nonzero bits were discarded
//   out_overflow           result saturated to infinity
module fixed_to_float_pipe #(
    parameter int unsigned IN_WIDTH = 32,
    parameter int unsigned EXP_W    = 8,
    parameter int unsigned MAN_W    = 23,
    localparam int unsigned POS_W   = $clog2(IN_WIDTH),
    localparam int unsigned RES_W   = 1 + EXP_W + MAN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] targetnumber,
    input  logic [POS_W-1:0]    fixpointpos,
    input  logic                in_signed,
    input  logic                in_round,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    result,
    output logic                out_inexact,
    output logic                out_overflow
);

    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX = (1 << EXP_W) - 1;
    // Exponent arithmetic width: covers p - fixpointpos + BIAS + carry without wrap.
    localparam int unsigned EW   = ((EXP_W > POS_W) ? EXP_W : POS_W) + 3;
    // Bits below the leading one, padded so guard/sticky always exist.
    localparam int unsigned XW   = IN_WIDTH + MAN_W + 1;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv || !rst;

    // ---------------- stage 1: capture sign and magnitude ----------------
    logic                s1_valid, s1_sign, s1_round;
    logic [IN_WIDTH-1:0] s1_mag;
    logic [POS_W-1:0]    s1_pos;
    logic                sign_c;
    logic [IN_WIDTH-1:0] mag_c;

    // Negating the most negative value wraps to 2^(IN_WIDTH-1), which is the correct magnitude.
    assign sign_c = in_signed & targetnumber[IN_WIDTH-1];
    assign mag_c  = sign_c ? (~targetnumber + IN_WIDTH'(1)) : targetnumber;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_round <= 1'b0;
            s1_mag   <= '0;
            s1_pos   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_sign  <= sign_c;
            s1_round <= in_round;
            s1_mag   <= mag_c;
            s1_pos   <= fixpointpos;
        end
    end

    // ---------------- stage 2: normalise ----------------
    logic                 s2_valid, s2_sign, s2_round, s2_zero;
    logic [IN_WIDTH-2:0]  s2_frac;
    logic signed [EW-1:0] s2_exp;
    logic [POS_W-1:0]     lead_c;
    logic [IN_WIDTH-2:0]  frac_c;
    logic signed [EW-1:0] exp_c;

    // Leading-one index; highest set bit wins.
    always_comb begin
        lead_c = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (s1_mag[i]) lead_c = POS_W'(i);
        end
    end

    // Leading one is implicit, so only the bits below it are kept.
    assign frac_c = (IN_WIDTH-1)'(s1_mag << (POS_W'(IN_WIDTH - 1) - lead_c));
    assign exp_c  = $signed(EW'(lead_c)) - $signed(EW'(s1_pos));

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_round <= 1'b0;
            s2_zero  <= 1'b0;
            s2_frac  <= '0;
            s2_exp   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_round <= s1_round;
            s2_zero  <= (s1_mag == '0);
            s2_frac  <= frac_c;
            s2_exp   <= exp_c;
        end
    end

    // ---------------- stage 3: round and pack ----------------
    logic [XW-1:0]        ext_c;
    logic [MAN_W-1:0]     mant_c;
    logic                 guard_c, sticky_c, rup_c;
    logic [MAN_W:0]       msum_c;
    logic signed [EW-1:0] ebias_c;
    logic [RES_W-1:0]     res_c;
    logic                 inex_c, ovf_c;

    assign ext_c    = {s2_frac, {(MAN_W + 2){1'b0}}};
    assign mant_c   = ext_c[XW-1 -: MAN_W];
    assign guard_c  = ext_c[XW-1-MAN_W];
    assign sticky_c = |ext_c[XW-2-MAN_W:0];
    assign rup_c    = s2_round & guard_c & (sticky_c | mant_c[0]);
    // A carry out leaves the low MAN_W bits at zero and bumps the exponent.
    assign msum_c   = {1'b0, mant_c} + (MAN_W+1)'(rup_c);
    assign ebias_c  = s2_exp + $signed(EW'(BIAS)) + $signed(EW'(msum_c[MAN_W]));

    always_comb begin
        res_c  = '0;
        inex_c = 1'b0;
        ovf_c  = 1'b0;
        if (!s2_zero) begin
            inex_c = guard_c | sticky_c;
            if (ebias_c >= $signed(EW'(EMAX))) begin
                res_c  = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                ovf_c  = 1'b1;
                inex_c = 1'b1;
            end else if (ebias_c[EW-1] || (ebias_c == '0)) begin
                // No subnormals: flush to signed zero.
                res_c  = {s2_sign, {(RES_W-1){1'b0}}};
                inex_c = 1'b1;
            end else begin
                res_c  = {s2_sign, ebias_c[EXP_W-1:0], msum_c[MAN_W-1:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            result       <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
        end else if (adv) begin
            out_valid    <= s2_valid;
            result       <= s2_valid ? res_c : '0;
            out_inexact  <= s2_valid & inex_c;
            out_overflow <= s2_valid & ovf_c;
        end
    end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Directed bench for fixed_to_float_pipe: single-precision instance plus a
// half-precision instance (EXP_W=5, MAN_W=10) for the over/underflow corners.
module tb_fixed_to_float_pipe;

    logic        clk;
    logic        rst;

    logic        iv, ir, ov, ordy, sg, rd, inx, ovf;
    logic [31:0] tn, res;
    logic [4:0]  pos;

    logic        h_iv, h_ir, h_ov, h_ordy, h_sg, h_rd, h_inx, h_ovf;
    logic [31:0] h_tn;
    logic [15:0] h_res;
    logic [4:0]  h_pos;

    int checks   = 0;
    int failures = 0;

    fixed_to_float_pipe #(.IN_WIDTH(32), .EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst),
        .in_valid(iv), .in_ready(ir),
        .targetnumber(tn), .fixpointpos(pos),
        .in_signed(sg), .in_round(rd),
        .out_valid(ov), .out_ready(ordy),
        .result(res), .out_inexact(inx), .out_overflow(ovf)
    );

    fixed_to_float_pipe #(.IN_WIDTH(32), .EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst),
        .in_valid(h_iv), .in_ready(h_ir),
        .targetnumber(h_tn), .fixpointpos(h_pos),
        .in_signed(h_sg), .in_round(h_rd),
        .out_valid(h_ov), .out_ready(h_ordy),
        .result(h_res), .out_inexact(h_inx), .out_overflow(h_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one transaction into the single-precision DUT and wait (bounded) for its result.
    task automatic convert(input logic [31:0] t, input logic [4:0] p, input logic s, input logic r,
                           output logic [31:0] rr, output logic ix, output logic ox, output int lat);
        @(negedge clk);
        tn = t; pos = p; sg = s; rd = r; iv = 1'b1; ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        lat = -1; rr = 'x; ix = 1'bx; ox = 1'bx;
        for (int n = 1; n <= 8; n++) begin
            if (n > 1) @(negedge clk);
            #1;
            if (ov) begin
                lat = n; rr = res; ix = inx; ox = ovf;
                break;
            end
        end
    endtask

    task automatic convert_h(input logic [31:0] t, input logic [4:0] p, input logic s, input logic r,
                             output logic [15:0] rr, output logic ix, output logic ox, output int lat);
        @(negedge clk);
        h_tn = t; h_pos = p; h_sg = s; h_rd = r; h_iv = 1'b1; h_ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        h_iv = 1'b0;
        lat = -1; rr = 'x; ix = 1'bx; ox = 1'bx;
        for (int n = 1; n <= 8; n++) begin
            if (n > 1) @(negedge clk);
            #1;
            if (h_ov) begin
                lat = n; rr = h_res; ix = h_inx; ox = h_ovf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ov !== 1'b0) begin $display("FAIL reset_out_valid got=%b exp=0", ov); failures++; end
        checks++; if (res !== 32'h0) begin $display("FAIL reset_result got=%h exp=00000000", res); failures++; end
        checks++; if (inx !== 1'b0) begin $display("FAIL reset_inexact got=%b exp=0", inx); failures++; end
        checks++; if (ovf !== 1'b0) begin $display("FAIL reset_overflow got=%b exp=0", ovf); failures++; end
        checks++; if (ir !== 1'b1) begin $display("FAIL reset_in_ready got=%b exp=1", ir); failures++; end
        checks++; if (h_ov !== 1'b0) begin $display("FAIL reset_h_out_valid got=%b exp=0", h_ov); failures++; end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] r; logic ix, ox; int lat;
        convert(32'h0000_0180, 5'd8, 1'b1, 1'b1, r, ix, ox, lat);
        checks++; if (r !== 32'h3FC0_0000) begin $display("FAIL basic_result got=%h exp=3fc00000", r); failures++; end
        checks++; if (lat !== 3) begin $display("FAIL basic_latency got=%0d exp=3", lat); failures++; end
        checks++; if (ix !== 1'b0) begin $display("FAIL basic_inexact got=%b exp=0", ix); failures++; end
        convert(32'h0, 5'd3, 1'b1, 1'b1, r, ix, ox, lat);
        checks++; if (r !== 32'h0) begin $display("FAIL zero_result got=%h exp=00000000", r); failures++; end
        checks++; if (ix !== 1'b0) begin $display("FAIL zero_inexact got=%b exp=0", ix); failures++; end
        checks++; if (ox !== 1'b0) begin $display("FAIL zero_overflow got=%b exp=0", ox); failures++; end
    endtask

    task automatic test_sign();
        logic [31:0] r; logic ix, ox; int lat;
        convert(32'hFFFF_FFFF, 5'd0, 1'b1, 1'b1, r, ix, ox, lat);
        checks++; if (r !== 32'hBF80_0000) begin $display("FAIL sign_minus1 got=%h exp=bf800000", r); failures++; end
        convert(32'h8000_0000, 5'd31, 1'b1, 1'b1, r, ix, ox, lat);
        checks++; if (r !== 32'hBF80_0000) begin $display("FAIL sign_most_negative got=%h exp=bf800000", r); failures++; end
        checks++; if (ix !== 1'b0) begin $display("FAIL sign_most_negative_inexact got=%b exp=0", ix); failures++; end
    endtask

    task automatic test_rounding();
        logic [31:0] r; logic ix, ox; int lat;
        convert(32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1, r, ix, ox, lat);
        checks++; if (r !== 32'h4F80_0000) begin $display("FAIL rne_carry got=%h exp=4f800000", r); failures++; end
        checks++; if (ix !== 1'b1) begin $display("FAIL rne_carry_inexact got=%b exp=1", ix); failures++; end
        convert(32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, r, ix, ox, lat);
        checks++; if (r !== 32'h4F7F_FFFF) begin $display("FAIL truncate got=%h exp=4f7fffff", r); failures++; end
        checks++; if (ix !== 1'b1) begin $display("FAIL truncate_inexact got=%b exp=1", ix); failures++; end
        convert(32'h0100_0001, 5'd0, 1'b0, 1'b1, r, ix, ox, lat);
        checks++; if (r !== 32'h4B80_0000) begin $display("FAIL tie_down got=%h exp=4b800000", r); failures++; end
        checks++; if (ix !== 1'b1) begin $display("FAIL tie_down_inexact got=%b exp=1", ix); failures++; end
        convert(32'h0100_0003, 5'd0, 1'b0, 1'b1, r, ix, ox, lat);
        checks++; if (r !== 32'h4B80_0002) begin $display("FAIL tie_up got=%h exp=4b800002", r); failures++; end
        checks++; if (ix !== 1'b1) begin $display("FAIL tie_up_inexact got=%b exp=1", ix); failures++; end
    endtask

    task automatic test_half();
        logic [15:0] r; logic ix, ox; int lat;
        convert_h(32'h0001_0000, 5'd0, 1'b0, 1'b1, r, ix, ox, lat);
        checks++; if (r !== 16'h7C00) begin $display("FAIL half_overflow_result got=%h exp=7c00", r); failures++; end
        checks++; if (ox !== 1'b1) begin $display("FAIL half_overflow_flag got=%b exp=1", ox); failures++; end
        checks++; if (ix !== 1'b1) begin $display("FAIL half_overflow_inexact got=%b exp=1", ix); failures++; end
        convert_h(32'h0000_0001, 5'd31, 1'b0, 1'b1, r, ix, ox, lat);
        checks++; if (r !== 16'h0000) begin $display("FAIL half_flush_result got=%h exp=0000", r); failures++; end
        checks++; if (ix !== 1'b1) begin $display("FAIL half_flush_inexact got=%b exp=1", ix); failures++; end
        checks++; if (ox !== 1'b0) begin $display("FAIL half_flush_overflow got=%b exp=0", ox); failures++; end
    endtask

    // Six integers 1..6 streamed back to back with a 4-cycle output stall mid-stream.
    task automatic test_back_to_back();
        logic [31:0] exp_q [6];
        int idx, k;
        exp_q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                  32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
        idx = 0; k = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            @(negedge clk);
            ordy = !(c >= 3 && c < 7);
            iv   = (idx < 6);
            tn   = 32'(idx + 1); pos = 5'd0; sg = 1'b0; rd = 1'b1;
            #1;
            if (ov) begin
                checks++;
                if (res !== exp_q[k]) begin
                    $display("FAIL stream_result idx=%0d cycle=%0d got=%h exp=%h", k, c, res, exp_q[k]); failures++;
                end
                if (!ordy) begin
                    checks++;
                    if (ir !== 1'b0) begin $display("FAIL stall_in_ready cycle=%0d got=%b exp=0", c, ir); failures++; end
                end else begin
                    k++;
                end
            end else begin
                checks++;
                if (ir !== 1'b1) begin $display("FAIL idle_in_ready cycle=%0d got=%b exp=1", c, ir); failures++; end
            end
            if (iv && ir) idx++;
        end
        iv = 1'b0; ordy = 1'b1;
        checks++; if (k != 6) begin $display("FAIL stream_count got=%0d exp=6", k); failures++; end
        checks++; if (idx != 6) begin $display("FAIL stream_accepted got=%0d exp=6", idx); failures++; end
    endtask

    // Two transactions in flight when reset hits; neither may emerge.
    task automatic test_reset_inflight();
        @(negedge clk);
        ordy = 1'b1; iv = 1'b1; tn = 32'd1; pos = 5'd0; sg = 1'b0; rd = 1'b1;
        @(negedge clk);
        tn = 32'd2;
        @(negedge clk);
        iv = 1'b0; rst = 1'b0;
        #1;
        checks++; if (ir !== 1'b1) begin $display("FAIL rst_in_ready_during got=%b exp=1", ir); failures++; end
        @(negedge clk);
        #1;
        checks++; if (ov !== 1'b0) begin $display("FAIL rst_inflight_valid got=%b exp=0", ov); failures++; end
        checks++; if (res !== 32'h0) begin $display("FAIL rst_inflight_result got=%h exp=00000000", res); failures++; end
        checks++; if (ir !== 1'b1) begin $display("FAIL rst_in_ready_after got=%b exp=1", ir); failures++; end
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checks++; if (ov !== 1'b0) begin $display("FAIL rst_stale_output cycle=%0d got=%b exp=0", c, ov); failures++; end
        end
    endtask

    initial begin
        rst = 1'b0;
        iv = 1'b0; ordy = 1'b1; tn = '0; pos = '0; sg = 1'b0; rd = 1'b0;
        h_iv = 1'b0; h_ordy = 1'b1; h_tn = '0; h_pos = '0; h_sg = 1'b0; h_rd = 1'b0;
        test_reset();
        test_basic();
        test_sign();
        test_rounding();
        test_half();
        test_back_to_back();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
